fetch_align_unit: RTL and testbench

- Instruction fetch stage directly upstream of the decode/control stage.
- Issues word-aligned reads to instruction memory and buffers the returned halfwords.
- Presents one instruction at a time with a valid/ready handshake: a full 32-bit instruction, or a 16-bit compressed instruction zero-extended in bits [15:0].
- Handles 32-bit instructions that straddle a word boundary, and redirects to halfword-aligned targets.

---
 rtl/fetch_align_unit_if.sv | 30 +++
 rtl/fetch_align_unit.sv | 132 +++++++++++++
 tb/tb_fetch_align_unit.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_align_unit_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : fetch_align_unit_if                                           |
// | Description : Memory-side and decode-side buses of the fetch align unit.    |
// | Revision    : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
interface fetch_align_unit_if;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ready;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr_out;
    logic [31:0] pc_out;

    modport master (
        output mem_req, mem_addr, instr_valid, instr_out, pc_out,
        input  mem_ready, mem_rvalid, mem_rdata, redirect, redirect_pc, instr_ready
    );

    modport slave (
        input  mem_req, mem_addr, instr_valid, instr_out, pc_out,
        output mem_ready, mem_rvalid, mem_rdata, redirect, redirect_pc, instr_ready
    );
endinterface
`default_nettype wire

// File: rtl/fetch_align_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : fetch_align_unit                                              |
// | Description : Word fetch with a 3-halfword buffer that realigns 16/32-bit   |
// |               instructions for decode.                                      |
// | Revision    : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module fetch_align_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  wire logic               clk,
    input  wire logic               rst,
    fetch_align_unit_if.master      bus
);

    localparam logic [31:0] c_FETCH_RESET = {RESET_PC[31:2], 2'b00};
    localparam logic [31:0] c_HEAD_RESET  = {RESET_PC[31:1], 1'b0};

    logic [31:0] r_fetch_addr;
    logic [15:0] r_buf [0:2];
    logic [1:0]  r_count;
    logic [31:0] r_head_pc;
    logic        r_outstanding;
    logic        r_drop;
    logic        r_skip_low;

    logic        w_head_is32;
    logic        w_instr_valid;
    logic        w_mem_req;
    logic        w_accept;
    logic        w_rsp;
    logic        w_append;
    logic        w_fire;
    logic [1:0]  w_consume;
    logic [1:0]  w_append_cnt;
    logic [1:0]  w_base;
    logic [15:0] w_first_hw;
    logic [15:0] w_buf_nxt [0:2];
    logic [1:0]  w_count_nxt;

    // Any low-bit pattern 11 needs a second halfword before it can be presented.
    assign w_head_is32   = &r_buf[0][1:0];
    assign w_instr_valid = w_head_is32 ? (r_count >= 2'd2) : (r_count != 2'd0);

    assign bus.instr_valid = w_instr_valid;
    assign bus.instr_out   = w_head_is32 ? {r_buf[1], r_buf[0]} : {16'h0000, r_buf[0]};
    assign bus.pc_out      = r_head_pc;

    // Only ask for a word when both of its halfwords are guaranteed to fit.
    assign w_mem_req    = !rst && !r_outstanding && (r_count <= 2'd1) && !bus.redirect;
    assign bus.mem_req  = w_mem_req;
    assign bus.mem_addr = r_fetch_addr;

    assign w_accept     = w_mem_req && bus.mem_ready;
    assign w_rsp        = bus.mem_rvalid && r_outstanding;
    assign w_append     = w_rsp && !r_drop && !bus.redirect;
    assign w_fire       = w_instr_valid && bus.instr_ready;
    assign w_consume    = !w_fire ? 2'd0 : (w_head_is32 ? 2'd2 : 2'd1);
    assign w_append_cnt = !w_append ? 2'd0 : (r_skip_low ? 2'd1 : 2'd2);
    assign w_base       = r_count - w_consume;
    assign w_first_hw   = r_skip_low ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
    assign w_count_nxt  = r_count + w_append_cnt - w_consume;

    // Shift out consumed halfwords first, then land new ones just past the survivors.
    always_comb begin
        w_buf_nxt[0] = r_buf[0];
        w_buf_nxt[1] = r_buf[1];
        w_buf_nxt[2] = r_buf[2];
        case (w_consume)
            2'd1: begin
                w_buf_nxt[0] = r_buf[1];
                w_buf_nxt[1] = r_buf[2];
                w_buf_nxt[2] = 16'h0000;
            end
            2'd2: begin
                w_buf_nxt[0] = r_buf[2];
                w_buf_nxt[1] = 16'h0000;
                w_buf_nxt[2] = 16'h0000;
            end
            default: ;
        endcase
        if (w_append) begin
            case (w_base)
                2'd0: begin
                    w_buf_nxt[0] = w_first_hw;
                    if (!r_skip_low) w_buf_nxt[1] = bus.mem_rdata[31:16];
                end
                2'd1: begin
                    w_buf_nxt[1] = w_first_hw;
                    if (!r_skip_low) w_buf_nxt[2] = bus.mem_rdata[31:16];
                end
                default: w_buf_nxt[2] = w_first_hw;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fetch_addr  <= c_FETCH_RESET;
            r_count       <= 2'd0;
            r_head_pc     <= c_HEAD_RESET;
            r_outstanding <= 1'b0;
            r_drop        <= 1'b0;
            r_skip_low    <= RESET_PC[1];
            for (int i = 0; i < 3; i++) r_buf[i] <= 16'h0000;
        end else if (bus.redirect) begin
            r_count       <= 2'd0;
            r_head_pc     <= bus.redirect_pc & ~32'd1;
            r_fetch_addr  <= {bus.redirect_pc[31:2], 2'b00};
            r_skip_low    <= bus.redirect_pc[1];
            // A response still in flight belongs to the old path.
            r_outstanding <= r_outstanding && !bus.mem_rvalid;
            r_drop        <= r_outstanding && !bus.mem_rvalid;
        end else begin
            for (int i = 0; i < 3; i++) r_buf[i] <= w_buf_nxt[i];
            r_count   <= w_count_nxt;
            r_head_pc <= r_head_pc + {29'd0, w_consume, 1'b0};
            if (w_accept) begin
                r_outstanding <= 1'b1;
                r_fetch_addr  <= r_fetch_addr + 32'd4;
            end else if (w_rsp) begin
                r_outstanding <= 1'b0;
            end
            if (w_rsp) begin
                r_drop <= 1'b0;
                if (!r_drop) r_skip_low <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fetch_align_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_fetch_align_unit                                           |
// | Description : Scoreboard bench for fetch_align_unit with a latency memory.  |
// | Revision    : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module tb_fetch_align_unit;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        int          cyc;
    } exp_t;

    logic clk;
    logic rst;
    fetch_align_unit_if bus();

    fetch_align_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    exp_t        exp_q [$];
    logic [31:0] acc_q [$];
    logic [31:0] mem [logic [31:0]];
    int          n_cmp = 0;
    int          n_err = 0;
    int          cyc;
    int          mem_lat = 0;
    logic        acc_flag = 1'b0;
    logic        rst_s = 1'b1;
    logic [31:0] acc_addr = 32'h0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    function automatic logic [31:0] mem_read(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return 32'h0001_0001;
    endfunction

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic [31:0] instr, input logic [31:0] pc, input int c);
        exp_t e;
        e.instr = instr;
        e.pc    = pc;
        e.cyc   = c;
        exp_q.push_back(e);
    endtask

    // Memory: sample acceptance mid-cycle, answer mem_lat+1 cycles later.
    initial forever begin
        @(negedge clk);
        rst_s    = rst;
        acc_flag = bus.mem_req && bus.mem_ready;
        acc_addr = bus.mem_addr;
        if (acc_flag) acc_q.push_back(acc_addr);
    end

    initial begin
        logic        pend;
        int          pend_cnt;
        logic [31:0] pend_addr;
        pend = 1'b0;
        pend_cnt = 0;
        pend_addr = 32'h0;
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = 32'h0;
        forever begin
            @(posedge clk);
            #1;
            bus.mem_rvalid = 1'b0;
            if (rst_s) begin
                pend = 1'b0;
            end else begin
                if (acc_flag) begin
                    pend      = 1'b1;
                    pend_cnt  = mem_lat;
                    pend_addr = acc_addr;
                end
                if (pend) begin
                    if (pend_cnt == 0) begin
                        bus.mem_rvalid = 1'b1;
                        bus.mem_rdata  = mem_read(pend_addr);
                        pend = 1'b0;
                    end else begin
                        pend_cnt--;
                    end
                end
            end
        end
    end

    // Monitor: every accepted instruction is matched against the queue head.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && bus.instr_valid && bus.instr_ready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_instr: got %h at pc %h, expected none", bus.instr_out, bus.pc_out);
                end else begin
                    e = exp_q.pop_front();
                    check32("instr_out", bus.instr_out, e.instr);
                    check32("pc_out", bus.pc_out, e.pc);
                    if (e.cyc >= 0) check32("handshake_cycle", 32'(cyc), 32'(e.cyc));
                end
            end
        end
    end

    task automatic do_reset(input logic rdy, input logic mrdy);
        rst = 1'b1;
        bus.redirect = 1'b0;
        bus.instr_ready = 1'b0;
        bus.mem_ready = mrdy;
        @(posedge clk);
        @(negedge clk);
        check32("reset_mem_req", 32'(bus.mem_req), 32'd0);
        check32("reset_instr_valid", 32'(bus.instr_valid), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.instr_ready = rdy;
        acc_q.delete();
        @(negedge clk);
        check32("first_mem_req", 32'(bus.mem_req), 32'd1);
        check32("first_mem_addr", bus.mem_addr, 32'h0);
        check32("first_instr_valid", 32'(bus.instr_valid), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int k = 0;
        bus.instr_ready = 1'b1;
        while (exp_q.size() != 0 && k < 200) begin
            @(posedge clk);
            #1;
            k++;
        end
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
            exp_q.delete();
        end
        bus.instr_ready = 1'b0;
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        bus.redirect = 1'b0;
        bus.redirect_pc = 32'h0;
        bus.instr_ready = 1'b0;
        bus.mem_ready = 1'b1;

        // Single 32-bit instruction, first valid two cycles after acceptance.
        mem.delete();
        mem[32'h0] = 32'h00A0_0093;
        do_reset(1'b1, 1'b1);
        push_exp(32'h00A0_0093, 32'h0, 2);
        drain();

        // Two compressed instructions in one word; next word fetched meanwhile.
        mem.delete();
        mem[32'h0] = 32'h4505_4501;
        do_reset(1'b1, 1'b1);
        push_exp(32'h0000_4501, 32'h0, 2);
        push_exp(32'h0000_4505, 32'h2, 3);
        drain();
        check32("prefetch_addr", (acc_q.size() > 1) ? acc_q[1] : 32'hFFFF_FFFF, 32'h4);

        // Straddling 32-bit instruction waits for the second word.
        mem.delete();
        mem[32'h0] = 32'h0093_4501;
        mem[32'h4] = 32'h4585_00A0;
        do_reset(1'b1, 1'b1);
        push_exp(32'h0000_4501, 32'h0, 2);
        push_exp(32'h00A0_0093, 32'h2, 5);
        drain();

        // Backpressure with three buffered halfwords.
        do_reset(1'b1, 1'b1);
        push_exp(32'h0000_4501, 32'h0, 2);
        drain();
        wait_cyc(5);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check32("bp_valid", 32'(bus.instr_valid), 32'd1);
            check32("bp_instr", bus.instr_out, 32'h00A0_0093);
            check32("bp_pc", bus.pc_out, 32'h2);
            check32("bp_mem_req", 32'(bus.mem_req), 32'd0);
            @(posedge clk);
            #1;
        end
        push_exp(32'h00A0_0093, 32'h2, -1);
        push_exp(32'h0000_4585, 32'h6, -1);
        drain();

        // Reset while the buffer is full.
        do_reset(1'b1, 1'b1);
        push_exp(32'h0000_4501, 32'h0, 2);
        drain();
        wait_cyc(5);
        @(negedge clk);
        check32("full_before_reset", 32'(bus.instr_valid), 32'd1);
        @(posedge clk);
        #1;
        do_reset(1'b1, 1'b1);
        push_exp(32'h0000_4501, 32'h0, 2);
        drain();

        // Redirect to a halfword target while a slow response is in flight.
        mem.delete();
        mem[32'h0]   = 32'h4501_4501;
        mem[32'h100] = 32'h4585_4501;
        mem[32'h104] = 32'h00A0_0093;
        mem_lat = 3;
        do_reset(1'b1, 1'b1);
        bus.redirect = 1'b1;
        bus.redirect_pc = 32'h0000_0102;
        @(negedge clk);
        check32("redirect_mem_req", 32'(bus.mem_req), 32'd0);
        @(posedge clk);
        #1;
        bus.redirect = 1'b0;
        @(negedge clk);
        check32("in_flight_mem_req", 32'(bus.mem_req), 32'd0);
        @(posedge clk);
        #1;
        push_exp(32'h0000_4585, 32'h102, -1);
        push_exp(32'h00A0_0093, 32'h104, -1);
        drain();
        check32("redirect_fetch_addr", (acc_q.size() > 1) ? acc_q[1] : 32'hFFFF_FFFF, 32'h100);
        check32("redirect_next_addr", (acc_q.size() > 2) ? acc_q[2] : 32'hFFFF_FFFF, 32'h104);
        mem_lat = 0;

        // Request held while memory stalls.
        mem.delete();
        mem[32'h0] = 32'h00A0_0093;
        do_reset(1'b1, 1'b0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check32("stall_mem_req", 32'(bus.mem_req), 32'd1);
            check32("stall_mem_addr", bus.mem_addr, 32'h0);
            @(posedge clk);
            #1;
        end
        bus.mem_ready = 1'b1;
        push_exp(32'h00A0_0093, 32'h0, 5);
        drain();

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
